// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the memory port arbiter.
package mem_arb_pkg;

  localparam int PORT_FETCH = 0;
  localparam int PORT_DATA  = 1;
  localparam int PORT_LOAD  = 2;

  typedef enum logic {
    LK_UNLOCKED = 1'b0,
    LK_LOCKED   = 1'b1
  } lk_state_t;

  // Index width for n ports; never less than 1 bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, response and memory bus signals of the arbiter.
interface mem_port_arbiter_if #(
  parameter int NREQ   = 3,
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);
  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0]             req_we;
  logic [NREQ-1:0]             req_lock;
  logic [NREQ-1:0][ADDR_W-1:0] req_addr;
  logic [NREQ-1:0][DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]             req_ready;
  logic [NREQ-1:0]             resp_valid;
  logic [DATA_W-1:0]           resp_rdata;
  logic [ADDR_W-1:0]           mem_addr;
  logic                        mem_we;
  logic                        mem_en;
  logic [DATA_W-1:0]           mem_wdata;
  logic [DATA_W-1:0]           mem_rdata;

  // Arbiter side.
  modport slave (
    input  req_valid, req_we, req_lock, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, mem_addr, mem_we, mem_en, mem_wdata
  );

  // Requesters plus memory side.
  modport master (
    output req_valid, req_we, req_lock, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, mem_addr, mem_we, mem_en, mem_wdata
  );
endinterface

// File: rtl/mem_arb_pick.sv
// Rotating priority encoder: first set request at or above rr_ptr, wrapping.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int IDX_W = clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx
);

  logic             found;
  int               j;
  logic [IDX_W-1:0] jj;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    jj    = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      jj = j[IDX_W-1:0];
      if (!found && req[jj]) begin
        found     = 1'b1;
        grant[jj] = 1'b1;
        idx       = jj;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter with per-port lock sharing one pipelined memory port;
// read responses are routed back through a port-index shift pipeline.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus
);

  localparam int IDX_W = clog2(NREQ);

  lk_state_t        lk_q, lk_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_q, rr_d;

  logic [NREQ-1:0]  pick_grant;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] win;
  logic [NREQ-1:0]  ready;
  logic             any;
  logic             locked_hit;

  // Stage 0 lines up with the registered command; stage MEM_LAT with rdata.
  logic [MEM_LAT:0]            vld_pipe;
  logic [MEM_LAT:0][IDX_W-1:0] idx_pipe;

  mem_arb_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
    .req    (bus.req_valid),
    .rr_ptr (rr_q),
    .grant  (pick_grant),
    .idx    (pick_idx)
  );

  always_comb begin
    locked_hit = (lk_q == LK_LOCKED) && bus.req_valid[owner_q];
    any        = |bus.req_valid;
    win        = locked_hit ? owner_q : pick_idx;
    ready      = '0;
    if (locked_hit) ready[owner_q] = 1'b1;
    else            ready = pick_grant;

    lk_d    = lk_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    if (any) begin
      if (bus.req_lock[win]) begin
        lk_d    = LK_LOCKED;
        owner_d = win;
      end else begin
        lk_d = LK_UNLOCKED;
        rr_d = (win == IDX_W'(NREQ - 1)) ? '0 : win + IDX_W'(1);
      end
    end else if (lk_q == LK_LOCKED) begin
      // Owner went idle with nobody else asking: drop the lock.
      lk_d = LK_UNLOCKED;
    end
  end

  assign bus.req_ready  = ready;
  assign bus.resp_rdata = bus.mem_rdata;

  always_comb begin
    bus.resp_valid = '0;
    if (vld_pipe[MEM_LAT]) bus.resp_valid[idx_pipe[MEM_LAT]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lk_q          <= LK_UNLOCKED;
      owner_q       <= '0;
      rr_q          <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      vld_pipe      <= '0;
      idx_pipe      <= '0;
    end else begin
      lk_q       <= lk_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      bus.mem_en <= any;
      bus.mem_we <= any & bus.req_we[win];
      if (any) begin
        bus.mem_addr  <= bus.req_addr[win];
        bus.mem_wdata <= bus.req_wdata[win];
      end
      vld_pipe <= {vld_pipe[MEM_LAT-1:0], any & ~bus.req_we[win]};
      idx_pipe <= {idx_pipe[MEM_LAT-1:0], win};
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: two arbiters (MEM_LAT 1 and 2) each with a small memory model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NREQ(3), .ADDR_W(15), .DATA_W(16)) b0();
  mem_port_arbiter_if #(.NREQ(3), .ADDR_W(15), .DATA_W(16)) b1();

  mem_port_arbiter #(.NREQ(3), .ADDR_W(15), .DATA_W(16), .MEM_LAT(1)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0));
  mem_port_arbiter #(.NREQ(3), .ADDR_W(15), .DATA_W(16), .MEM_LAT(2)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1));

  logic [15:0] mem0 [0:255];
  logic [15:0] mem1 [0:255];
  logic [15:0] rd0, rd1a, rd1b;
  logic        pl_we = 1'b0;
  logic [7:0]  pl_a = '0;
  logic [15:0] pl_d = '0;

  always @(posedge clk) begin
    if (pl_we) mem0[pl_a] <= pl_d;
    else if (b0.mem_en && b0.mem_we) mem0[b0.mem_addr[7:0]] <= b0.mem_wdata;
    rd0 <= (b0.mem_en && !b0.mem_we) ? mem0[b0.mem_addr[7:0]] : 16'h0;
    if (b1.mem_en && b1.mem_we) mem1[b1.mem_addr[7:0]] <= b1.mem_wdata;
    rd1a <= (b1.mem_en && !b1.mem_we) ? mem1[b1.mem_addr[7:0]] : 16'h0;
    rd1b <= rd1a;
  end

  assign b0.mem_rdata = rd0;
  assign b1.mem_rdata = rd1b;

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    b0.req_valid = '0; b0.req_we = '0; b0.req_lock = '0;
    b0.req_addr  = '0; b0.req_wdata = '0;
    b1.req_valid = '0; b1.req_we = '0; b1.req_lock = '0;
    b1.req_addr  = '0; b1.req_wdata = '0;
  endtask

  int cnt [3];
  int p;

  logic [2:0]  t3_rdy  [6] = '{3'b001, 3'b010, 3'b010, 3'b010, 3'b001, 3'b000};
  logic [14:0] t3_addr [5] = '{15'h30, 15'h10, 15'h11, 15'h12, 15'h30};
  logic [15:0] t3_data [5] = '{16'h0000, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'h0000};

  logic [2:0] t4_vld [6] = '{3'b100, 3'b111, 3'b001, 3'b100, 3'b000, 3'b111};
  logic [2:0] t4_lck [6] = '{3'b100, 3'b100, 3'b000, 3'b100, 3'b000, 3'b000};
  logic [2:0] t4_rdy [6] = '{3'b100, 3'b100, 3'b001, 3'b100, 3'b000, 3'b010};

  initial begin
    idle();
    tick(); tick();
    chk("rst_mem_en",    32'(b0.mem_en), 0);
    chk("rst_mem_we",    32'(b0.mem_we), 0);
    chk("rst_mem_addr",  32'(b0.mem_addr), 0);
    chk("rst_mem_wdata", 32'(b0.mem_wdata), 0);
    chk("rst_resp0",     32'(b0.resp_valid), 0);
    chk("rst_resp1",     32'(b1.resp_valid), 0);
    rst_n = 1'b1;

    pl_we = 1'b1;
    pl_a = 8'h04; pl_d = 16'h8123; tick();
    pl_a = 8'h40; pl_d = 16'h1000; tick();
    pl_a = 8'h41; pl_d = 16'h1001; tick();
    pl_a = 8'h42; pl_d = 16'h1002; tick();
    pl_we = 1'b0;

    // single read on fetch port
    b0.req_valid = 3'b001; b0.req_addr[PORT_FETCH] = 15'h0004; #1;
    chk("t1_ready", 32'(b0.req_ready), 'b001);
    tick(); b0.req_valid = '0; #1;
    chk("t1_mem_en",   32'(b0.mem_en), 1);
    chk("t1_mem_we",   32'(b0.mem_we), 0);
    chk("t1_mem_addr", 32'(b0.mem_addr), 'h0004);
    chk("t1_resp_t1",  32'(b0.resp_valid), 0);
    tick(); #1;
    chk("t1_resp",  32'(b0.resp_valid), 'b001);
    chk("t1_rdata", 32'(b0.resp_rdata), 'h8123);

    // round-robin fairness from a fresh rr pointer
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cnt[i] = 0;
    for (int k = 0; k < 9; k++) begin
      tick();
      b0.req_valid = (k < 6) ? 3'b111 : 3'b000;
      for (int i = 0; i < 3; i++) b0.req_addr[i] = 15'(15'h40 + i);
      #1;
      chk($sformatf("t2_ready_%0d", k), 32'(b0.req_ready), (k < 6) ? (1 << (k % 3)) : 0);
      if (k >= 2 && k < 8) begin
        p = (k - 2) % 3;
        chk($sformatf("t2_resp_%0d", k), 32'(b0.resp_valid), 1 << p);
        chk($sformatf("t2_rdata_%0d", k), 32'(b0.resp_rdata), 'h1000 + p);
      end else begin
        chk($sformatf("t2_noresp_%0d", k), 32'(b0.resp_valid), 0);
      end
      for (int i = 0; i < 3; i++) if (b0.resp_valid[i]) cnt[i]++;
    end
    for (int i = 0; i < 3; i++) chk($sformatf("t2_cnt%0d", i), 32'(cnt[i]), 2);

    // lock on data port for three writes while fetch stays valid
    idle();
    for (int k = 0; k < 6; k++) begin
      tick();
      b0.req_we = 3'b011;
      b0.req_valid = {1'b0, (k >= 1 && k <= 3), (k < 5)};
      b0.req_lock  = {1'b0, (k == 1 || k == 2), 1'b0};
      b0.req_addr[PORT_FETCH]  = 15'h30;
      b0.req_wdata[PORT_FETCH] = 16'h0000;
      if (k >= 1 && k <= 3) begin
        b0.req_addr[PORT_DATA]  = t3_addr[k];
        b0.req_wdata[PORT_DATA] = t3_data[k];
      end
      #1;
      chk($sformatf("t3_ready_%0d", k), 32'(b0.req_ready), 32'(t3_rdy[k]));
      chk($sformatf("t3_noresp_%0d", k), 32'(b0.resp_valid), 0);
      if (k >= 1) begin
        chk($sformatf("t3_mem_en_%0d", k),   32'(b0.mem_en), 1);
        chk($sformatf("t3_mem_we_%0d", k),   32'(b0.mem_we), 1);
        chk($sformatf("t3_mem_addr_%0d", k), 32'(b0.mem_addr), 32'(t3_addr[k-1]));
        chk($sformatf("t3_mem_data_%0d", k), 32'(b0.mem_wdata), 32'(t3_data[k-1]));
      end
    end
    chk("t3_word10", 32'(mem0[8'h10]), 'hAAAA);
    chk("t3_word11", 32'(mem0[8'h11]), 'hBBBB);
    chk("t3_word12", 32'(mem0[8'h12]), 'hCCCC);

    // loader lock, release on valid drop (with and without a competitor)
    idle();
    for (int k = 0; k < 6; k++) begin
      tick();
      b0.req_we = 3'b111;
      b0.req_valid = t4_vld[k];
      b0.req_lock  = t4_lck[k];
      for (int i = 0; i < 3; i++) b0.req_addr[i] = 15'(15'h50 + i);
      #1;
      chk($sformatf("t4_ready_%0d", k), 32'(b0.req_ready), 32'(t4_rdy[k]));
    end

    // write then read on the MEM_LAT=2 instance
    idle();
    tick();
    b1.req_valid = 3'b010; b1.req_we = 3'b010;
    b1.req_addr[PORT_DATA] = 15'h0020; b1.req_wdata[PORT_DATA] = 16'h5555; #1;
    chk("t5_ready_w", 32'(b1.req_ready), 'b010);
    tick();
    b1.req_valid = 3'b001; b1.req_we = 3'b000; b1.req_addr[PORT_FETCH] = 15'h0020; #1;
    chk("t5_ready_r", 32'(b1.req_ready), 'b001);
    chk("t5_mem_we",  32'(b1.mem_we), 1);
    chk("t5_mem_wd",  32'(b1.mem_wdata), 'h5555);
    chk("t5_noresp1", 32'(b1.resp_valid), 0);
    tick(); b1.req_valid = '0; #1;
    chk("t5_rd_en",   32'(b1.mem_en), 1);
    chk("t5_rd_we",   32'(b1.mem_we), 0);
    chk("t5_noresp2", 32'(b1.resp_valid), 0);
    tick(); #1;
    chk("t5_noresp3", 32'(b1.resp_valid), 0);
    tick(); #1;
    chk("t5_resp",  32'(b1.resp_valid), 'b001);
    chk("t5_rdata", 32'(b1.resp_rdata), 'h5555);
    tick(); #1;
    chk("t5_resp_end", 32'(b1.resp_valid), 0);

    // reset right after a read accept
    idle();
    tick();
    b0.req_valid = 3'b001; b0.req_addr = '0; b0.req_addr[PORT_FETCH] = 15'h0004; #1;
    chk("t6_ready", 32'(b0.req_ready), 'b001);
    tick(); b0.req_valid = '0; rst_n = 1'b0; #1;
    chk("t6_mem_en_cmd", 32'(b0.mem_en), 1);
    tick(); rst_n = 1'b1; #1;
    chk("t6_noresp",  32'(b0.resp_valid), 0);
    chk("t6_mem_en0", 32'(b0.mem_en), 0);
    tick();
    b0.req_valid = 3'b111; #1;
    chk("t6_first",   32'(b0.req_ready), 'b001);
    chk("t6_noresp2", 32'(b0.resp_valid), 0);
    tick(); b0.req_valid = '0; #1;
    chk("t6_mem_addr", 32'(b0.mem_addr), 'h0004);
    tick(); #1;
    chk("t6_resp",  32'(b0.resp_valid), 'b001);
    chk("t6_rdata", 32'(b0.resp_rdata), 'h8123);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
